// File: rtl/pwm_audio_out.sv
// Four-voice time-multiplexed mixer with master volume feeding a 10-bit PWM audio pin.
// The duty register reloads only when the PWM counter wraps, so each period is glitch-free.
module pwm_audio_out (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample1,
  input  logic [7:0] sample2,
  input  logic [7:0] sample3,
  input  logic [7:0] sample4,
  input  logic [3:0] voice_en,
  input  logic [3:0] volume,
  output logic       pwm_out,
  output logic       frame_tick
);

  logic [1:0]        phase_q, phase_d;
  logic [9:0]        acc_q, acc_d;
  logic [9:0]        mix_q, mix_d;
  logic [9:0]        duty_next_q, duty_next_d;
  logic [9:0]        duty_q, duty_d;
  logic [9:0]        pwm_cnt_q, pwm_cnt_d;
  logic              pwm_out_q, pwm_out_d;
  logic              frame_tick_q, frame_tick_d;

  logic [7:0]        samples [4];
  logic [7:0]        contrib [4];
  logic [7:0]        voice_c;
  logic signed [10:0] centered;
  logic signed [14:0] prod;
  logic signed [14:0] scaled;
  logic              cnt_wrap;

  assign samples[0] = sample1;
  assign samples[1] = sample2;
  assign samples[2] = sample3;
  assign samples[3] = sample4;

  // A disabled voice sits at mid-scale so it adds nothing audible to the mix.
  for (genvar gi = 0; gi < 4; gi++) begin : g_contrib
    assign contrib[gi] = voice_en[gi] ? samples[gi] : 8'd128;
  end

  assign voice_c  = contrib[phase_q];
  assign cnt_wrap = (pwm_cnt_q == 10'd1023);

  // Mix is re-centred on zero, scaled by volume/16 with floor rounding, then shifted back.
  assign centered = $signed({1'b0, mix_q}) - 11'sd512;
  assign prod     = 15'(centered) * $signed({11'd0, volume});
  assign scaled   = prod >>> 4;

  always_comb begin
    phase_d      = phase_q + 2'd1;
    acc_d        = acc_q;
    mix_d        = mix_q;
    duty_next_d  = scaled[9:0] + 10'd512;
    duty_d       = duty_q;
    pwm_cnt_d    = pwm_cnt_q + 10'd1;
    pwm_out_d    = (pwm_cnt_q < duty_q);
    frame_tick_d = cnt_wrap;
    case (phase_q)
      2'd0:       acc_d = {2'b00, voice_c};
      2'd1, 2'd2: acc_d = acc_q + {2'b00, voice_c};
      default:    mix_d = acc_q + {2'b00, voice_c};
    endcase
    if (cnt_wrap) begin
      duty_d = duty_next_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q      <= 2'd0;
      acc_q        <= 10'd0;
      mix_q        <= 10'd512;
      duty_next_q  <= 10'd512;
      duty_q       <= 10'd512;
      pwm_cnt_q    <= 10'd0;
      pwm_out_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      acc_q        <= acc_d;
      mix_q        <= mix_d;
      duty_next_q  <= duty_next_d;
      duty_q       <= duty_d;
      pwm_cnt_q    <= pwm_cnt_d;
      pwm_out_q    <= pwm_out_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign pwm_out    = pwm_out_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Self-checking bench for pwm_audio_out: measures whole PWM periods and compares the
// high-time against duty computed arithmetically from the mixer/volume rules.
module tb_pwm_audio_out;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s1 = 8'd128, s2 = 8'd128, s3 = 8'd128, s4 = 8'd128;
  logic [3:0] en = 4'hF;
  logic [3:0] vol = 4'd15;
  logic       pwm_out;
  logic       frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_audio_out dut (
    .clk        (clk),
    .rst        (rst),
    .sample1    (s1),
    .sample2    (s2),
    .sample3    (s3),
    .sample4    (s4),
    .voice_en   (en),
    .volume     (vol),
    .pwm_out    (pwm_out),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference: duty = 512 + floor((sum of contributions - 512) * volume / 16).
  function automatic int ref_duty(input int a, input int b, input int c, input int d,
                                  input int e, input int v);
    int mix, p, q;
    mix = (e[0] ? a : 128) + (e[1] ? b : 128) + (e[2] ? c : 128) + (e[3] ? d : 128);
    p = (mix - 512) * v;
    q = p / 16;
    if (p < 0 && (p % 16) != 0) q = q - 1;
    return 512 + q;
  endfunction

  task automatic set_inputs(input int a, input int b, input int c, input int d,
                            input int e, input int v);
    s1 = 8'(a); s2 = 8'(b); s3 = 8'(c); s4 = 8'(d);
    en = 4'(e); vol = 4'(v);
  endtask

  // Advances to the next negedge at which frame_tick is high, bounded.
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Starting on a frame_tick cycle, observes one full 1024-cycle period.
  task automatic measure_here(output int high, output int edges, output int ticks);
    logic prev;
    high = 0; edges = 0; ticks = 0; prev = pwm_out;
    for (int i = 0; i < 1024; i++) begin
      if (pwm_out === 1'b1) high++;
      if (i > 0 && pwm_out !== prev) edges++;
      if (frame_tick === 1'b1) ticks++;
      prev = pwm_out;
      @(negedge clk);
    end
  endtask

  task automatic settle_and_measure(output int high, output int edges, output int ticks,
                                    output bit ok);
    bit ok1, ok2;
    wait_tick(ok1);
    wait_tick(ok2);
    ok = ok1 & ok2;
    high = 0; edges = 0; ticks = 0;
    if (ok) measure_here(high, edges, ticks);
  endtask

  task automatic check_release(input string tag);
    int first;
    first = -1;
    rst = 1'b0;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if (pwm_out !== 1'b1 || frame_tick !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_first_edge: pwm_out=%b frame_tick=%b, required 1 and 0", tag, pwm_out, frame_tick);
        end
      end
      if (frame_tick === 1'b1) begin
        first = k;
        break;
      end
    end
    n_checks++;
    if (first != 1024) begin
      n_fail++;
      $display("FAIL %s_first_tick: first frame_tick at cycle %0d, required 1024", tag, first);
    end
    $display("release %s: first frame_tick at cycle %0d", tag, first);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_inputs(128, 128, 128, 128, 15, 15);
    repeat (3) @(negedge clk);
    n_checks++;
    if (pwm_out !== 1'b0 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: pwm_out=%b frame_tick=%b, required 0 and 0", pwm_out, frame_tick);
    end
    check_release("reset");
  endtask

  task automatic test_levels();
    int cfg [7][6] = '{
      '{128, 128, 128, 128, 15, 15},
      '{255, 255, 255, 255, 15, 15},
      '{  0,   0,   0,   0, 15, 15},
      '{200, 200, 200, 200, 15, 15},
      '{  0,   0,   0,   0, 15,  7},
      '{  0,   0,   0,   0, 15,  0},
      '{ 17, 250,   3, 199,  0, 15}
    };
    int req [7] = '{512, 988, 32, 782, 288, 512, 512};
    int high, edges, ticks, model;
    bit ok;
    for (int t = 0; t < 7; t++) begin
      set_inputs(cfg[t][0], cfg[t][1], cfg[t][2], cfg[t][3], cfg[t][4], cfg[t][5]);
      model = ref_duty(cfg[t][0], cfg[t][1], cfg[t][2], cfg[t][3], cfg[t][4], cfg[t][5]);
      settle_and_measure(high, edges, ticks, ok);
      n_checks++;
      if (!ok || high != req[t] || model != req[t] || edges != 2 || ticks != 1) begin
        n_fail++;
        $display("FAIL level_%0d: high=%0d edges=%0d ticks=%0d ok=%0b, required high=%0d edges=2 ticks=1",
                 t, high, edges, ticks, ok, req[t]);
      end
      $display("level %0d: high=%0d expected=%0d", t, high, req[t]);
    end
  endtask

  task automatic test_random();
    int a, b, c, d, e, v, model, high, edges, ticks;
    bit ok;
    for (int t = 0; t < 5; t++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      c = $urandom_range(0, 255); d = $urandom_range(0, 255);
      e = $urandom_range(0, 15);  v = $urandom_range(0, 15);
      set_inputs(a, b, c, d, e, v);
      model = ref_duty(a, b, c, d, e, v);
      settle_and_measure(high, edges, ticks, ok);
      n_checks++;
      if (!ok || high != model || edges != 2 || ticks != 1) begin
        n_fail++;
        $display("FAIL random_%0d: high=%0d edges=%0d ticks=%0d, required high=%0d edges=2 ticks=1 (s=%0d/%0d/%0d/%0d en=%h vol=%0d)",
                 t, high, edges, ticks, model, a, b, c, d, e, v);
      end
      $display("random %0d: s=%0d/%0d/%0d/%0d en=%h vol=%0d high=%0d expected=%0d",
               t, a, b, c, d, e, v, high, model);
    end
  endtask

  task automatic test_mid_period();
    int high, edges, ticks;
    bit ok1, ok2;
    logic prev;
    set_inputs(128, 128, 128, 128, 15, 15);
    wait_tick(ok1);
    wait_tick(ok2);
    high = 0; edges = 0; ticks = 0; prev = pwm_out;
    for (int i = 0; i < 1024; i++) begin
      if (i == 300) set_inputs(255, 255, 255, 255, 15, 15);
      if (pwm_out === 1'b1) high++;
      if (i > 0 && pwm_out !== prev) edges++;
      prev = pwm_out;
      @(negedge clk);
    end
    n_checks++;
    if (!(ok1 && ok2) || high != 512 || edges != 2) begin
      n_fail++;
      $display("FAIL mid_current: high=%0d edges=%0d, required high=512 edges=2", high, edges);
    end
    $display("mid-period current: high=%0d expected=512", high);
    measure_here(high, edges, ticks);
    n_checks++;
    if (high != 988 || edges != 2 || ticks != 1) begin
      n_fail++;
      $display("FAIL mid_next: high=%0d edges=%0d ticks=%0d, required high=988 edges=2 ticks=1", high, edges, ticks);
    end
    $display("mid-period next: high=%0d expected=988", high);
  endtask

  task automatic test_phase_isolation();
    int high [2];
    int edges [2];
    bit ok1, ok2;
    logic prev;
    set_inputs(128, 128, 128, 128, 15, 15);
    wait_tick(ok1);
    wait_tick(ok2);
    high = '{0, 0}; edges = '{0, 0}; prev = pwm_out;
    // pwm_cnt and phase both clear on reset and advance together, so i%4 is the phase.
    for (int i = 0; i < 2048; i++) begin
      if (pwm_out === 1'b1) high[i / 1024]++;
      if ((i % 1024) > 0 && pwm_out !== prev) edges[i / 1024]++;
      prev = pwm_out;
      s2 = ((i % 4) == 1) ? 8'd128 : (($urandom_range(0, 1) != 0) ? 8'd255 : 8'd0);
      @(negedge clk);
    end
    s2 = 8'd128;
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (!(ok1 && ok2) || high[p] != 512 || edges[p] != 2) begin
        n_fail++;
        $display("FAIL phase_iso_%0d: high=%0d edges=%0d, required high=512 edges=2", p, high[p], edges[p]);
      end
      $display("phase isolation period %0d: high=%0d expected=512", p, high[p]);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    set_inputs(128, 128, 128, 128, 15, 15);
    wait_tick(ok);
    repeat (100) @(negedge clk);
    n_checks++;
    if (!ok || pwm_out !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: pwm_out=%b at pwm_cnt=100, required 1", pwm_out);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (pwm_out !== 1'b0 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: pwm_out=%b frame_tick=%b before next edge, required 0 and 0", pwm_out, frame_tick);
    end
    $display("async reset: pwm_out=%b after assertion", pwm_out);
    repeat (2) @(negedge clk);
    check_release("rerelease");
  endtask

  initial begin
    test_reset();
    test_levels();
    test_random();
    test_mid_period();
    test_phase_isolation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
